// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM states,
// parity-mode encodings and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Caller zero-extends the word, so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0] mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~x;
      PAR_EVEN: parity_bit = x;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus/serial signal bundle for uart_tx_fifo; slave is the transmitter side.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
);
  logic [DATA_BITS-1:0] din;
  logic                 load;
  logic                 shift;
  logic [1:0]           parity_mode;
  logic                 stop2;
  logic                 clr_ovf;
  logic                 txd;
  logic                 ready;
  logic                 busy;
  logic [CNT_W-1:0]     count;
  logic                 overflow;

  modport master (
    output din, load, shift, parity_mode, stop2, clr_ovf,
    input  txd, ready, busy, count, overflow
  );

  modport slave (
    input  din, load, shift, parity_mode, stop2, clr_ovf,
    output txd, ready, busy, count, overflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with fill count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == {CNT_W{1'b0}});
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a holding FIFO; one bit per shift strobe,
// run-time parity and stop-bit selection latched per frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input logic           clock,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   txd_q, txd_d;
  logic [1:0]             mode_q, mode_d;
  logic                   stop2_q, stop2_d;
  logic                   par_q, par_d;
  logic                   overflow_q, overflow_d;
  logic                   pop, full, empty, frame_end;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [MAX_DATA_BITS-1:0] par_in;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.load),
    .pop   (pop),
    .wdata (bus.din),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  assign bus.txd      = txd_q;
  assign bus.ready    = !full;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    txd_d      = txd_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    pop        = 1'b0;
    par_in     = '0;
    par_in[DATA_BITS-1:0] = fifo_rdata;
    frame_end  = (state_q == IDLE) || (state_q == STOP2) ||
                 ((state_q == STOP1) && !stop2_q);
    if (bus.shift) begin
      if (frame_end) begin
        // IDLE and the last stop bit both launch the next queued word directly.
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          mode_d  = bus.parity_mode;
          stop2_d = bus.stop2;
          par_d   = parity_bit(par_in, bus.parity_mode);
          txd_d   = 1'b0;
          state_d = START;
        end else begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          START: begin
            txd_d     = shreg_q[0];
            bit_cnt_d = '0;
            state_d   = DATA;
          end
          DATA: begin
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              if (mode_q != PAR_NONE) begin
                txd_d   = par_q;
                state_d = PARITY;
              end else begin
                txd_d   = 1'b1;
                state_d = STOP1;
              end
            end else begin
              shreg_d   = shreg_q >> 1;
              txd_d     = shreg_q[1];
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
          PARITY: begin
            txd_d   = 1'b1;
            state_d = STOP1;
          end
          STOP1: begin
            txd_d   = 1'b1;
            state_d = STOP2;
          end
          default: begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
    // A drop and a clear in the same cycle leave the flag set.
    if (bus.load && full && !pop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      mode_q     <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DATA_BITS=8, FIFO_DEPTH=4).
module tb_uart_tx_fifo;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_fifo_if #(.DATA_BITS(8), .CNT_W(3)) u_if ();

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    u_if.load = 1'b1;
    u_if.din  = d;
    step();
    u_if.load = 1'b0;
  endtask

  // Shift every 4 clocks; config is flipped after the pop to prove it was latched.
  task automatic run_frame(input logic [7:0] data, input logic [1:0] mode, input logic s2,
                           input logic exp_par, input logic [2:0] exp_cnt,
                           input logic ld, input logic [7:0] ld_data);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = data[i]; n++; end
    if (mode != 2'b00) begin bits[n] = exp_par; n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    u_if.parity_mode = mode;
    u_if.stop2       = s2;
    for (int i = 0; i < n; i++) begin
      u_if.shift = 1'b1;
      if (i == 0) begin
        u_if.load = ld;
        u_if.din  = ld_data;
      end
      step();
      u_if.shift = 1'b0;
      u_if.load  = 1'b0;
      if (i == 0) begin
        chk($sformatf("pop_count_%0h", data), u_if.count, exp_cnt);
        u_if.parity_mode = ~mode;
        u_if.stop2       = ~s2;
      end
      chk($sformatf("txd_%0h_bit%0d", data, i), u_if.txd, bits[i]);
      chk($sformatf("busy_%0h_bit%0d", data, i), u_if.busy, 1'b1);
      repeat (3) step();
      chk($sformatf("hold_%0h_bit%0d", data, i), u_if.txd, bits[i]);
    end
  endtask

  task automatic end_frame(input string tag);
    u_if.shift = 1'b1;
    step();
    u_if.shift = 1'b0;
    chk({tag, "_txd"}, u_if.txd, 1'b1);
    chk({tag, "_busy"}, u_if.busy, 1'b0);
    chk({tag, "_count"}, u_if.count, 3'd0);
    step();
  endtask

  initial begin
    u_if.din = 8'h00;   u_if.load = 1'b0;  u_if.shift = 1'b0;
    u_if.parity_mode = 2'b00; u_if.stop2 = 1'b0; u_if.clr_ovf = 1'b0;

    // Reset overrides a simultaneous load and shift.
    reset = 1'b0;
    step();
    u_if.load = 1'b1; u_if.din = 8'h55; u_if.shift = 1'b1;
    step();
    u_if.load = 1'b0; u_if.shift = 1'b0;
    chk("rst_txd", u_if.txd, 1'b1);
    chk("rst_ready", u_if.ready, 1'b1);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_count", u_if.count, 3'd0);
    chk("rst_ovf", u_if.overflow, 1'b0);
    reset = 1'b1;
    step();

    // Test 1: load on a shift edge is not popped until the following shift.
    u_if.load = 1'b1; u_if.din = 8'hA5; u_if.shift = 1'b1;
    step();
    u_if.load = 1'b0; u_if.shift = 1'b0;
    chk("t1_load_count", u_if.count, 3'd1);
    chk("t1_load_busy", u_if.busy, 1'b0);
    chk("t1_load_txd", u_if.txd, 1'b1);
    step();
    run_frame(8'hA5, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    end_frame("t1_end");

    // Test 2: parity modes on 0xA5 (four ones).
    load_word(8'hA5);
    run_frame(8'hA5, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    end_frame("t2_even_end");
    load_word(8'hA5);
    run_frame(8'hA5, 2'b01, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
    end_frame("t2_odd_end");
    load_word(8'hA5);
    run_frame(8'hA5, 2'b11, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
    end_frame("t2_mark_end");

    // Test 3: two stop bits, back-to-back frames.
    load_word(8'h3C);
    load_word(8'hC3);
    chk("t3_count2", u_if.count, 3'd2);
    run_frame(8'h3C, 2'b00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00);
    run_frame(8'hC3, 2'b00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
    end_frame("t3_end");

    // Test 4: fill past full with shift idle.
    for (int i = 0; i < 5; i++) begin
      load_word(8'(i + 1));
      chk($sformatf("t4_count_%0d", i), u_if.count, (i < 4) ? i + 1 : 4);
      chk($sformatf("t4_ready_%0d", i), u_if.ready, (i < 3) ? 1 : 0);
      chk($sformatf("t4_ovf_%0d", i), u_if.overflow, (i == 4) ? 1 : 0);
    end
    u_if.clr_ovf = 1'b1;
    step();
    u_if.clr_ovf = 1'b0;
    chk("t4_clr_ovf", u_if.overflow, 1'b0);
    u_if.clr_ovf = 1'b1;
    load_word(8'h07);
    u_if.clr_ovf = 1'b0;
    chk("t4_set_wins", u_if.overflow, 1'b1);
    chk("t4_drop_count", u_if.count, 3'd4);
    u_if.clr_ovf = 1'b1;
    step();
    u_if.clr_ovf = 1'b0;
    chk("t4_clr_again", u_if.overflow, 1'b0);

    // Test 5: load on the pop edge of a full FIFO is accepted.
    run_frame(8'h01, 2'b00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h06);
    chk("t5_no_ovf", u_if.overflow, 1'b0);
    run_frame(8'h02, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00);
    run_frame(8'h03, 2'b00, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00);
    run_frame(8'h04, 2'b00, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00);
    run_frame(8'h06, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
    end_frame("t5_end");

    // Test 6: reset during data bit 3 of 0x11 (bit3 = 0) with two words queued.
    load_word(8'h11);
    load_word(8'h22);
    load_word(8'h33);
    u_if.parity_mode = 2'b00; u_if.stop2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      u_if.shift = 1'b1;
      step();
      u_if.shift = 1'b0;
      repeat (3) step();
    end
    chk("t6_pre_txd", u_if.txd, 1'b0);
    chk("t6_pre_count", u_if.count, 3'd2);
    reset = 1'b0;
    step();
    chk("t6_rst_txd", u_if.txd, 1'b1);
    chk("t6_rst_busy", u_if.busy, 1'b0);
    chk("t6_rst_count", u_if.count, 3'd0);
    chk("t6_rst_ready", u_if.ready, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      u_if.shift = ~u_if.shift;
      step();
      chk($sformatf("t6_post_txd_%0d", i), u_if.txd, 1'b1);
      chk($sformatf("t6_post_busy_%0d", i), u_if.busy, 1'b0);
    end
    u_if.shift = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
